// File: rtl/ysyx_23060240_mem_pkg.sv
// Shared encodings and default widths for the IFU/LSU memory arbiter.
// MEM_ARB_RR_EN selects round-robin arbitration instead of LSU priority.
package ysyx_23060240_mem_pkg;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int MASK_W       = 8;
  localparam int STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IFU  = 2'd1,
    OWN_LSU  = 2'd2
  } owner_e;

  function automatic int starve_w(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/ysyx_23060240_mem_arbiter_if.sv
// Requester and memory bundle of the arbiter.
// slave = arbiter side, master = IFU/LSU/SRAM side.
interface ysyx_23060240_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MASK_W = 8
);

  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_resp_valid;
  logic [DATA_W-1:0] ifu_rdata;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic              lsu_wen;
  logic [ADDR_W-1:0] lsu_addr;
  logic [DATA_W-1:0] lsu_wdata;
  logic [MASK_W-1:0] lsu_wmask;
  logic              lsu_resp_valid;
  logic [DATA_W-1:0] lsu_rdata;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_wmask;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata,
    input  lsu_req_valid, lsu_wen, lsu_addr,
    input  lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata,
    output mem_req_valid, mem_wen, mem_addr,
    output mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
    output lsu_req_valid, lsu_wen, lsu_addr,
    output lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
    input  mem_req_valid, mem_wen, mem_addr,
    input  mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );

endinterface

// File: rtl/ysyx_23060240_mem_arb_pick.sv
// Pure grant decision between IFU and LSU.
// MEM_ARB_RR_EN: round-robin; otherwise LSU priority with starvation escape.
module ysyx_23060240_mem_arb_pick
  import ysyx_23060240_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int STARVE_W     = 3
) (
  input  logic                ifu_valid_i,
  input  logic                lsu_valid_i,
  input  owner_e              last_i,
  input  logic [STARVE_W-1:0] starve_i,
  output logic                grant_ifu_o,
  output logic                grant_lsu_o
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic prefer_ifu;

`ifdef MEM_ARB_RR_EN
  assign prefer_ifu = (last_i == OWN_LSU);
  wire unused_starve = ^starve_i;
`else
  assign prefer_ifu = (starve_i == LIMIT);
  wire unused_last = ^last_i;
`endif

  always_comb begin
    grant_ifu_o = 1'b0;
    grant_lsu_o = 1'b0;
    unique case (1'b1)
      ifu_valid_i && !lsu_valid_i:               grant_ifu_o = 1'b1;
      lsu_valid_i && !ifu_valid_i:               grant_lsu_o = 1'b1;
      ifu_valid_i && lsu_valid_i && prefer_ifu:  grant_ifu_o = 1'b1;
      ifu_valid_i && lsu_valid_i && !prefer_ifu: grant_lsu_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_23060240_mem_arbiter.sv
// Single-outstanding IFU/LSU arbiter in front of the shared SRAM port.
// Define MEM_ARB_RR_EN for round-robin; default is LSU priority + starvation cap.
module ysyx_23060240_mem_arbiter
  import ysyx_23060240_mem_pkg::*;
#(
  parameter int ADDR_W       = ysyx_23060240_mem_pkg::ADDR_W,
  parameter int DATA_W       = ysyx_23060240_mem_pkg::DATA_W,
  parameter int MASK_W       = ysyx_23060240_mem_pkg::MASK_W,
  parameter int STARVE_LIMIT = ysyx_23060240_mem_pkg::STARVE_LIMIT
) (
  input logic                        clk,
  input logic                        rst_n,
  ysyx_23060240_mem_arbiter_if.slave bus
);

  localparam int SW = starve_w(STARVE_LIMIT);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  state_e            state_q,  state_d;
  owner_e            owner_q,  owner_d;
  owner_e            last_q,   last_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              wen_q,    wen_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic [DATA_W-1:0] wdata_q,  wdata_d;
  logic [MASK_W-1:0] wmask_q,  wmask_d;

  logic grant_ifu;
  logic grant_lsu;
  logic ifu_ready;
  logic lsu_ready;
  logic ifu_resp;
  logic lsu_resp;

  ysyx_23060240_mem_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .STARVE_W     (SW)
  ) u_pick (
    .ifu_valid_i (bus.ifu_req_valid),
    .lsu_valid_i (bus.lsu_req_valid),
    .last_i      (last_q),
    .starve_i    (starve_q),
    .grant_ifu_o (grant_ifu),
    .grant_lsu_o (grant_lsu)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    starve_d  = starve_q;
    wen_d     = wen_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    ifu_ready = 1'b0;
    lsu_ready = 1'b0;
    ifu_resp  = 1'b0;
    lsu_resp  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_lsu) begin
          lsu_ready = 1'b1;
          owner_d   = OWN_LSU;
          last_d    = OWN_LSU;
          wen_d     = bus.lsu_wen;
          addr_d    = bus.lsu_addr;
          wdata_d   = bus.lsu_wdata;
          wmask_d   = bus.lsu_wmask;
          state_d   = ST_REQ;
          if (!bus.ifu_req_valid) begin
            starve_d = '0;
          end else if (starve_q != LIMIT) begin
            starve_d = starve_q + 1'b1;
          end
        end else if (grant_ifu) begin
          ifu_ready = 1'b1;
          owner_d   = OWN_IFU;
          last_d    = OWN_IFU;
          wen_d     = 1'b0;
          addr_d    = bus.ifu_addr;
          wdata_d   = '0;
          wmask_d   = '0;
          starve_d  = '0;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.mem_req_ready) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.mem_resp_valid) begin
          ifu_resp = (owner_q == OWN_IFU);
          lsu_resp = (owner_q == OWN_LSU);
          owner_d  = OWN_NONE;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef MEM_ARB_RR_EN
    starve_d = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_NONE;
      last_q   <= OWN_NONE;
      starve_q <= '0;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      starve_q <= starve_d;
      wen_q    <= wen_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
    end
  end

  assign bus.ifu_req_ready  = ifu_ready;
  assign bus.lsu_req_ready  = lsu_ready;
  assign bus.ifu_resp_valid = ifu_resp;
  assign bus.lsu_resp_valid = lsu_resp;
  assign bus.ifu_rdata      = ifu_resp ? bus.mem_rdata : '0;
  // Stores are acknowledged with zero data, whatever the memory drives.
  assign bus.lsu_rdata      = (lsu_resp && !wen_q) ? bus.mem_rdata : '0;

  assign bus.mem_req_valid  = (state_q == ST_REQ);
  assign bus.mem_wen        = wen_q;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_wdata      = wdata_q;
  assign bus.mem_wmask      = wmask_q;

endmodule

// File: tb/tb_ysyx_23060240_mem_arbiter.sv
// Directed self-checking bench for ysyx_23060240_mem_arbiter.
// Honours MEM_ARB_RR_EN for the expected grant order.
module tb_ysyx_23060240_mem_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   who;

  ysyx_23060240_mem_arbiter_if bus ();

  ysyx_23060240_mem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.ifu_req_valid  = 1'b0;
    bus.ifu_addr       = '0;
    bus.lsu_req_valid  = 1'b0;
    bus.lsu_wen        = 1'b0;
    bus.lsu_addr       = '0;
    bus.lsu_wdata      = '0;
    bus.lsu_wmask      = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // Entered at IDLE with requests settled; returns at the next IDLE.
  task automatic txn(input logic hold, output int granted);
    granted = bus.lsu_req_ready ? 2 : (bus.ifu_req_ready ? 1 : 0);
    @(negedge clk);
    if (!hold) begin
      if (granted == 2) bus.lsu_req_valid = 1'b0;
      else if (granted == 1) bus.ifu_req_valid = 1'b0;
    end
    bus.mem_req_ready = 1'b1;
    #1;
    @(negedge clk);
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h0bad_0000;
    #1;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    #1;
  endtask

  int exp_seq [6];

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    clear_inputs();
`ifdef MEM_ARB_RR_EN
    exp_seq = '{2, 1, 2, 1, 2, 1};
`else
    exp_seq = '{2, 2, 2, 2, 1, 2};
`endif
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_req_valid", 32'(bus.mem_req_valid), 0);
    check("rst_ifu_ready", 32'(bus.ifu_req_ready), 0);
    check("rst_lsu_ready", 32'(bus.lsu_req_ready), 0);
    check("rst_ifu_resp", 32'(bus.ifu_resp_valid), 0);
    check("rst_lsu_resp", 32'(bus.lsu_resp_valid), 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    rst_n = 1'b1;

    // IFU fetch, response two cycles after acceptance
    @(negedge clk);
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0000;
    #1;
    check("f_ifu_ready", 32'(bus.ifu_req_ready), 1);
    check("f_lsu_ready", 32'(bus.lsu_req_ready), 0);
    @(negedge clk);
    bus.ifu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    #1;
    check("f_mem_valid", 32'(bus.mem_req_valid), 1);
    check("f_mem_addr", bus.mem_addr, 32'h8000_0000);
    check("f_mem_wen", 32'(bus.mem_wen), 0);
    check("f_mem_wmask", 32'(bus.mem_wmask), 0);
    check("f_ifu_ready_once", 32'(bus.ifu_req_ready), 0);
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    #1;
    check("f_mem_valid_drop", 32'(bus.mem_req_valid), 0);
    check("f_no_early_resp", 32'(bus.ifu_resp_valid), 0);
    @(negedge clk);
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h1234_5678;
    #1;
    check("f_ifu_resp", 32'(bus.ifu_resp_valid), 1);
    check("f_ifu_rdata", bus.ifu_rdata, 32'h1234_5678);
    check("f_lsu_resp", 32'(bus.lsu_resp_valid), 0);
    @(negedge clk);
    #1;
    check("idle_stale_ifu", 32'(bus.ifu_resp_valid), 0);
    check("idle_stale_lsu", 32'(bus.lsu_resp_valid), 0);
    check("idle_mem_valid", 32'(bus.mem_req_valid), 0);
    bus.mem_resp_valid = 1'b0;

    // LSU store
    @(negedge clk);
    bus.lsu_req_valid = 1'b1;
    bus.lsu_wen       = 1'b1;
    bus.lsu_addr      = 32'h0000_0010;
    bus.lsu_wdata     = 32'hdead_beef;
    bus.lsu_wmask     = 8'h0f;
    #1;
    check("w_lsu_ready", 32'(bus.lsu_req_ready), 1);
    @(negedge clk);
    bus.lsu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    #1;
    check("w_mem_wen", 32'(bus.mem_wen), 1);
    check("w_mem_addr", bus.mem_addr, 32'h0000_0010);
    check("w_mem_wdata", bus.mem_wdata, 32'hdead_beef);
    check("w_mem_wmask", 32'(bus.mem_wmask), 32'h0f);
    @(negedge clk);
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'hffff_ffff;
    #1;
    check("w_lsu_resp", 32'(bus.lsu_resp_valid), 1);
    check("w_lsu_rdata", bus.lsu_rdata, 0);
    check("w_ifu_resp", 32'(bus.ifu_resp_valid), 0);
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    bus.lsu_wen        = 1'b0;
    #1;
    check("w_lsu_resp_pulse", 32'(bus.lsu_resp_valid), 0);

    // Simultaneous requests
    do_reset();
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h0000_0200;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h0000_0300;
    #1;
    txn(1'b0, who);
    check("both_first", 32'(who), 2);
    txn(1'b0, who);
    check("both_second", 32'(who), 1);

    // Memory stalls for five cycles while LSU waits
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h0000_0100;
    #1;
    check("s_ifu_ready", 32'(bus.ifu_req_ready), 1);
    @(negedge clk);
    bus.ifu_req_valid = 1'b0;
    bus.ifu_addr      = 32'h0000_0999;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h0000_0444;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("s_mem_valid%0d", i), 32'(bus.mem_req_valid), 1);
      check($sformatf("s_mem_addr%0d", i), bus.mem_addr, 32'h0000_0100);
      check($sformatf("s_no_grant%0d", i), 32'(bus.lsu_req_ready), 0);
      @(negedge clk);
    end
    bus.lsu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    #1;
    @(negedge clk);
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'hcafe_f00d;
    #1;
    check("s_ifu_resp", 32'(bus.ifu_resp_valid), 1);
    check("s_ifu_rdata", bus.ifu_rdata, 32'hcafe_f00d);
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    #1;
    check("drop_no_ready", 32'(bus.lsu_req_ready), 0);
    @(negedge clk);
    #1;
    check("drop_no_req", 32'(bus.mem_req_valid), 0);

    // Reset while waiting for the response
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h0000_0500;
    #1;
    @(negedge clk);
    bus.ifu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    #1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("r_mem_valid", 32'(bus.mem_req_valid), 0);
    check("r_mem_addr", bus.mem_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h5555_aaaa;
    #1;
    check("r_stale_ifu", 32'(bus.ifu_resp_valid), 0);
    check("r_stale_lsu", 32'(bus.lsu_resp_valid), 0);
    check("r_stale_rdata", bus.ifu_rdata, 0);
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    #1;
    check("r_mem_valid_after", 32'(bus.mem_req_valid), 0);
    bus.lsu_req_valid = 1'b1;
    #1;
    check("r_idle_grant", 32'(bus.lsu_req_ready), 1);

    // Both held continuously: grant order
    do_reset();
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h0000_0600;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h0000_0700;
    #1;
    for (int i = 0; i < 6; i++) begin
      txn(1'b1, who);
      check($sformatf("order%0d", i), 32'(who), 32'(exp_seq[i]));
    end
    clear_inputs();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
